// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps a 3-input combinational function through all
// eight minterms and captures its output into an 8-bit truth table. It then
// publishes summary statistics and a comparison against a reference
// signature.
`timescale 1ns/1ps

module truth_table_scanner #(
    parameter int          SETTLE   = 1,      // hold cycles per minterm before sampling, 1..15
    parameter logic [7:0]  EXPECTED = 8'hE0   // reference truth table, bit[m] = expected s
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       s_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic [2:0] m_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic [3:0] ones_count,
    output logic [2:0] first_one,
    output logic       valid_first,
    output logic       match
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        FINISH
    } state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    state_t     state_q;
    logic [2:0] m_q;
    logic [3:0] cnt_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] cap_q;
    logic [7:0] cap_d;
    logic [7:0] table_q;
    logic [3:0] ones_q;
    logic [2:0] first_q;
    logic       valid_q;
    logic       match_q;

    // Population count over the eight captured bits; 4 bits so 8 does not wrap.
    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Index of the lowest set bit, 0 when the vector is empty.
    function automatic logic [2:0] lowest_one(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Capture register as it will look after the current cycle: in SAMPLE the
    // bit for the applied minterm takes s_in, so the final bit is included
    // when the results are published on the same edge.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        cap_d = cap_q;
        if (state_q == SAMPLE) begin
            cap_d[m_q] = s_in;
        end
    end

    // Scan sequencer with registered control and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the capture register is reset along with everything else, so
        // an aborted scan can never leak stale bits into a later result.
        if (rst) begin
            state_q <= IDLE;
            m_q     <= 3'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cap_q   <= 8'h00;
            table_q <= 8'h00;
            ones_q  <= 4'd0;
            first_q <= 3'd0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // updates from the pre-edge values regardless of statement order.
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= APPLY;
                        m_q     <= 3'd0;
                        cnt_q   <= RELOAD;
                        busy_q  <= 1'b1;
                    end
                end
                APPLY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                SAMPLE: begin
                    cap_q <= cap_d;
                    if (m_q == 3'd7) begin
                        state_q <= FINISH;
                        m_q     <= 3'd0;
                        done_q  <= 1'b1;
                        table_q <= cap_d;
                        ones_q  <= count_ones(cap_d);
                        first_q <= lowest_one(cap_d);
                        valid_q <= |cap_d;
                        match_q <= (cap_d == EXPECTED);
                    end else begin
                        state_q <= APPLY;
                        m_q     <= m_q + 3'd1;
                        cnt_q   <= RELOAD;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_out       = m_q;
    assign a_out       = m_q[2];
    assign b_out       = m_q[1];
    assign c_out       = m_q[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign table_out   = table_q;
    assign ones_count  = ones_q;
    assign first_one   = first_q;
    assign valid_first = valid_q;
    assign match       = match_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3) are
// compared every cycle against a timeline model of the scan, with directed
// scans pinning literal results and a randomized start/s_in phase.
`timescale 1ns/1ps

module tb_truth_table_scanner;

    localparam int         ST0 = 1;
    localparam int         ST1 = 3;
    localparam logic [7:0] EXP = 8'hE0;

    localparam int M_FUNC  = 0;
    localparam int M_ZERO  = 1;
    localparam int M_ONE   = 2;
    localparam int M_RAND  = 3;
    localparam int M_DELAY = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_s [2];
    logic       s_in_s  [2];
    logic       a_o     [2];
    logic       b_o     [2];
    logic       c_o     [2];
    logic [2:0] m_o     [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic [7:0] table_o [2];
    logic [3:0] ones_o  [2];
    logic [2:0] first_o [2];
    logic       valid_o [2];
    logic       match_o [2];

    int   mode   [2];
    logic s_rand [2];
    logic d1, d2;

    int checks = 0;
    int errors = 0;

    truth_table_scanner #(.SETTLE(ST0), .EXPECTED(EXP)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .s_in(s_in_s[0]),
        .a_out(a_o[0]), .b_out(b_o[0]), .c_out(c_o[0]), .m_out(m_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .table_out(table_o[0]),
        .ones_count(ones_o[0]), .first_one(first_o[0]),
        .valid_first(valid_o[0]), .match(match_o[0])
    );

    truth_table_scanner #(.SETTLE(ST1), .EXPECTED(EXP)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .s_in(s_in_s[1]),
        .a_out(a_o[1]), .b_out(b_o[1]), .c_out(c_o[1]), .m_out(m_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .table_out(table_o[1]),
        .ones_count(ones_o[1]), .first_one(first_o[1]),
        .valid_first(valid_o[1]), .match(match_o[1])
    );

    function automatic logic f3(input logic a, input logic b, input logic c);
        return a & (b | c);
    endfunction

    // Function under test, optionally behind two register stages (instance 1).
    always @(posedge clk) begin
        d1 <= f3(a_o[1], b_o[1], c_o[1]);
        d2 <= d1;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            s_in_s[i] = 1'b0;
            case (mode[i])
                M_FUNC:  s_in_s[i] = f3(a_o[i], b_o[i], c_o[i]);
                M_ONE:   s_in_s[i] = 1'b1;
                M_RAND:  s_in_s[i] = s_rand[i];
                M_DELAY: s_in_s[i] = d2;
                default: s_in_s[i] = 1'b0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // t_m = cycles elapsed since the start-accepting edge (-1 when idle).
    // Minterm m occupies cycles m*P .. m*P+P-1 (P = SETTLE+1); s_in is taken
    // at the end of the last of those cycles; done is the cycle t = 8*P.
    int         t_m   [2] = '{-1, -1};
    logic [7:0] cap_m [2] = '{8'h00, 8'h00};
    logic [7:0] tab_m [2] = '{8'h00, 8'h00};

    function automatic int per(input int i);
        return (i == 0) ? ST0 + 1 : ST1 + 1;
    endfunction

    function automatic logic [16:0] results_of(input logic [7:0] tab);
        int fo;
        fo = 0;
        for (int j = 7; j >= 0; j--) begin
            if (tab[j]) fo = j;
        end
        return {tab, 4'($countones(tab)), 3'(fo), tab != 8'h00, tab == EXP};
    endfunction

    // Single compare process: on each falling edge apply async reset,
    // compare the DUT against the model, then advance the model one edge.
    always @(negedge clk) begin
        int         p;
        int         em;
        logic       eb, ed;
        logic [7:0] ctrl_e, ctrl_a;
        for (int i = 0; i < 2; i++) begin
            p = per(i);
            if (rst) begin
                t_m[i]   = -1;
                cap_m[i] = 8'h00;
                tab_m[i] = 8'h00;
            end
            eb = (t_m[i] >= 0);
            ed = (t_m[i] == 8 * p);
            em = (t_m[i] >= 0 && t_m[i] < 8 * p) ? t_m[i] / p : 0;
            ctrl_e = {eb, ed, 3'(em), 3'(em)};
            ctrl_a = {busy_o[i], done_o[i], m_o[i], a_o[i], b_o[i], c_o[i]};
            check($sformatf("ctrl%0d", i), 32'(ctrl_a), 32'(ctrl_e));
            check($sformatf("results%0d", i),
                  32'({table_o[i], ones_o[i], first_o[i], valid_o[i], match_o[i]}),
                  32'(results_of(tab_m[i])));
            if (!rst) begin
                if (t_m[i] < 0) begin
                    if (start_s[i]) t_m[i] = 0;
                end else begin
                    if (t_m[i] < 8 * p && (t_m[i] % p) == p - 1) begin
                        cap_m[i][t_m[i] / p] = s_in_s[i];
                        if (t_m[i] == 8 * p - 1) tab_m[i] = cap_m[i];
                    end
                    if (t_m[i] == 8 * p) t_m[i] = -1;
                    else t_m[i] = t_m[i] + 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One scan on instance i; optionally pulse start again at cycles 3 and 10.
    task automatic run_scan(input int i, input bit inject);
        int n;
        int extra;
        start_s[i] = 1'b1;
        tick();
        start_s[i] = 1'b0;
        n = 0;
        while (!done_o[i] && n < 400) begin
            start_s[i] = inject && (n == 3 || n == 10);
            tick();
            n++;
        end
        start_s[i] = 1'b0;
        check($sformatf("done_latency%0d", i), 32'(n), 32'(8 * per(i)));
        extra = 0;
        repeat (40) begin
            tick();
            if (done_o[i]) extra++;
        end
        check($sformatf("extra_done%0d", i), 32'(extra), 32'd0);
    endtask

    task automatic expect_results(input int i, input string name, input logic [7:0] tab,
                                  input logic [3:0] ones, input logic [2:0] fo,
                                  input logic vf, input logic mt);
        check({name, "_table"}, 32'(table_o[i]), 32'(tab));
        check({name, "_ones"},  32'(ones_o[i]),  32'(ones));
        check({name, "_first"}, 32'(first_o[i]), 32'(fo));
        check({name, "_valid"}, 32'(valid_o[i]), 32'(vf));
        check({name, "_match"}, 32'(match_o[i]), 32'(mt));
    endtask

    initial begin
        int  n;
        bit  partial_seen;
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        s_rand[0]  = 1'b0; s_rand[1]  = 1'b0;
        mode[0]    = M_FUNC;
        mode[1]    = M_DELAY;
        rst        = 1'b1;
        tick();
        tick();
        expect_results(0, "reset", 8'h00, 4'd0, 3'd0, 1'b0, 1'b0);
        check("reset_busy", 32'(busy_o[0]), 32'd0);
        rst = 1'b0;
        tick();

        // s = a&(b|c), SETTLE=1
        run_scan(0, 1'b0);
        expect_results(0, "func", 8'hE0, 4'd3, 3'd5, 1'b1, 1'b1);
        check("model_pin", 32'(tab_m[0]), 32'h0000_00E0);

        // tied low / tied high
        mode[0] = M_ZERO;
        run_scan(0, 1'b0);
        expect_results(0, "zero", 8'h00, 4'd0, 3'd0, 1'b0, 1'b0);
        mode[0] = M_ONE;
        run_scan(0, 1'b0);
        expect_results(0, "one", 8'hFF, 4'd8, 3'd0, 1'b1, 1'b0);

        // extra start pulses during the scan are ignored
        mode[0] = M_FUNC;
        run_scan(0, 1'b1);
        expect_results(0, "inject", 8'hE0, 4'd3, 3'd5, 1'b1, 1'b1);

        // SETTLE=3 against a function delayed by two register stages
        run_scan(1, 1'b0);
        expect_results(1, "delay", 8'hE0, 4'd3, 3'd5, 1'b1, 1'b1);

        // asynchronous reset while m=3
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        n = 0;
        while (m_o[0] != 3'd3 && n < 100) begin
            tick();
            n++;
        end
        check("reach_m3", 32'(m_o[0]), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("async_ctrl", 32'({busy_o[0], done_o[0], m_o[0], a_o[0], b_o[0], c_o[0]}), 32'd0);
        expect_results(0, "async", 8'h00, 4'd0, 3'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        run_scan(0, 1'b0);
        expect_results(0, "after_rst", 8'hE0, 4'd3, 3'd5, 1'b1, 1'b1);

        // back-to-back scans with start held high
        mode[0]    = M_ZERO;
        start_s[0] = 1'b1;
        n = 0;
        while (!done_o[0] && n < 400) begin
            tick();
            n++;
        end
        check("hold1_table", 32'(table_o[0]), 32'h0);
        mode[0] = M_ONE;
        tick();
        n = 0;
        partial_seen = 1'b0;
        while (!done_o[0] && n < 400) begin
            if (table_o[0] != 8'h00) partial_seen = 1'b1;
            tick();
            n++;
        end
        start_s[0] = 1'b0;
        check("hold2_partial", 32'(partial_seen), 32'd0);
        check("hold2_latency", 32'(n), 32'd17);
        check("hold2_table", 32'(table_o[0]), 32'hFF);
        repeat (5) tick();

        // randomized starts and s_in on both instances
        mode[0] = M_RAND;
        mode[1] = M_RAND;
        repeat (800) begin
            for (int i = 0; i < 2; i++) begin
                start_s[i] = ($urandom_range(0, 7) == 0);
                s_rand[i]  = 1'($urandom_range(0, 1));
            end
            tick();
        end
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        repeat (50) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
